chuan_kou: RTL and testbench



---
 rtl/chuan_kou_pkg.sv | 20 ++
 rtl/chuan_kou_if.sv | 20 ++
 rtl/chuan_kou_uart_rx_core.sv | 112 +++++++++++
 rtl/chuan_kou.sv | 99 +++++++++
 tb/tb_chuan_kou.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/chuan_kou_pkg.sv
// Shared constants, baud-divider helper and receive-FSM encoding for the chuan_kou UART.
package chuan_kou_pkg;
    localparam int CLK_FREQ_DEFAULT = 100_000_000;
    localparam int BAUD_DEFAULT     = 9600;
    localparam int OVERSAMPLE       = 16;
    localparam int FRAME_BITS       = 10;

    // sys_clk cycles per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

    typedef enum logic [2:0] {
        RXS_IDLE,
        RXS_START,
        RXS_DATA,
        RXS_STOP,
        RXS_WAIT_HIGH
    } rx_state_e;
endpackage

// File: rtl/chuan_kou_if.sv
// Peripheral-side signal bundle of the chuan_kou UART: serial pins plus TX/RX byte handshake.
interface chuan_kou_if;
    logic       UART_RX;
    logic       UART_TX;
    logic [7:0] TX_DATA;
    logic       TX_EN;
    logic       TX_STATUS;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;

    modport master (
        output UART_RX, TX_DATA, TX_EN,
        input  UART_TX, TX_STATUS, RX_DATA, RX_STATUS
    );

    modport slave (
        input  UART_RX, TX_DATA, TX_EN,
        output UART_TX, TX_STATUS, RX_DATA, RX_STATUS
    );
endinterface

// File: rtl/chuan_kou_uart_rx_core.sv
// Receive path: 2-flop synchroniser, free-running 16x oversample tick and 8N1 deserialiser FSM.
module uart_rx_core
    import chuan_kou_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_status
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic          sync1_q, sync2_q, prev_q;
    logic [DW-1:0] div_q, div_d;
    logic          tick;
    rx_state_e     state_q, state_d;
    logic [3:0]    tcnt_q, tcnt_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          stat_q, stat_d;

    assign tick  = (div_q == DW'(DIV - 1));
    assign div_d = tick ? '0 : div_q + DW'(1);

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        stat_d  = 1'b0;
        case (state_q)
            RXS_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RXS_START;
                    tcnt_d  = '0;
                end
            end
            RXS_START: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    // Half a bit in: a line already back high was only a glitch.
                    if (tcnt_q == 4'd7) begin
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = sync2_q ? RXS_IDLE : RXS_DATA;
                    end
                end
            end
            RXS_DATA: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        shift_d = {sync2_q, shift_q[7:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) state_d = RXS_STOP;
                    end
                end
            end
            RXS_STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        if (sync2_q) begin
                            data_d  = shift_q;
                            stat_d  = 1'b1;
                            state_d = RXS_IDLE;
                        end else begin
                            state_d = RXS_WAIT_HIGH;
                        end
                    end
                end
            end
            RXS_WAIT_HIGH: begin
                if (sync2_q) state_d = RXS_IDLE;
            end
            default: state_d = RXS_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            div_q   <= '0;
            state_q <= RXS_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            stat_q  <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            div_q   <= div_d;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            stat_q  <= stat_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_status = stat_q;
endmodule

// File: rtl/chuan_kou.sv
// Full-duplex 8N1 UART: inline transmitter plus uart_rx_core receiver, all on sys_clk.
module chuan_kou
    import chuan_kou_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter int BAUD     = BAUD_DEFAULT,
    parameter int DIV      = calc_div(CLK_FREQ, BAUD)
) (
    input  logic       sys_clk,
    input  logic       reset,
    chuan_kou_if.slave bus
);
    localparam int BIT = OVERSAMPLE * DIV;
    localparam int CW  = $clog2(BIT);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    logic          en_q, en_prev_q;
    logic [8:0]    tx_shift_q, tx_shift_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          uart_tx_q, uart_tx_d;
    logic          tx_status_q, tx_status_d;
    logic          tx_accept;

    // Rise of the registered TX_EN while idle; rises during SEND are dropped.
    assign tx_accept = en_q && !en_prev_q && (tx_state_q == TX_IDLE);

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_shift_d  = tx_shift_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        uart_tx_d   = uart_tx_q;
        tx_status_d = tx_status_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_accept) begin
                    tx_state_d  = TX_SEND;
                    tx_shift_d  = {1'b1, bus.TX_DATA};
                    clk_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    uart_tx_d   = 1'b0;
                    tx_status_d = 1'b0;
                end
            end
            TX_SEND: begin
                clk_cnt_d = clk_cnt_q + CW'(1);
                if (clk_cnt_q == CW'(BIT - 1)) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                        tx_state_d  = TX_IDLE;
                        uart_tx_d   = 1'b1;
                        tx_status_d = 1'b1;
                    end else begin
                        uart_tx_d  = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tx_state_q  <= TX_IDLE;
            en_q        <= 1'b0;
            en_prev_q   <= 1'b0;
            tx_shift_q  <= '1;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            uart_tx_q   <= 1'b1;
            tx_status_q <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            en_q        <= bus.TX_EN;
            en_prev_q   <= en_q;
            tx_shift_q  <= tx_shift_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            uart_tx_q   <= uart_tx_d;
            tx_status_q <= tx_status_d;
        end
    end

    assign bus.UART_TX   = uart_tx_q;
    assign bus.TX_STATUS = tx_status_q;

    uart_rx_core #(.DIV(DIV)) u_rx (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .rx_in     (bus.UART_RX),
        .rx_data   (bus.RX_DATA),
        .rx_status (bus.RX_STATUS)
    );
endmodule

// File: tb/tb_chuan_kou.sv
// Scoreboard bench for chuan_kou: directed + randomized frames, TX/RX monitors check against queued expectations.
module tb_chuan_kou;
    import chuan_kou_pkg::*;

    localparam int TB_CLK_FREQ = 614_400;
    localparam int TB_BAUD     = 9600;
    localparam int BIT         = 64;

    typedef struct { logic [7:0] data; int req; bit ab; } tx_item_t;
    typedef struct { logic [7:0] data; int fall; } rx_item_t;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_line = 1'b1;
    logic       loop_en = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         tx_free = 0;
    logic [7:0] last_good = 8'h00;
    tx_item_t   tx_exp[$];
    rx_item_t   rx_exp[$];

    chuan_kou_if bus();
    assign bus.UART_RX = loop_en ? bus.UART_TX : rx_line;

    chuan_kou #(.CLK_FREQ(TB_CLK_FREQ), .BAUD(TB_BAUD)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Model: a rise is accepted only if the previous frame has fully ended (641 cycles after its request).
    task automatic tx_request(input logic [7:0] d, input int hold, input bit ab);
        bus.TX_DATA = d;
        bus.TX_EN   = 1'b1;
        if (cyc >= tx_free) begin
            tx_exp.push_back('{data: d, req: cyc, ab: ab});
            tx_free = cyc + 10 * BIT + 1;
            if (loop_en && !ab) rx_exp.push_back('{data: d, fall: cyc + 2});
        end
        repeat (hold) @(negedge sys_clk);
        bus.TX_EN = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, d, 1'b0};
        if (stop_ok) rx_exp.push_back('{data: d, fall: cyc});
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            repeat (BIT) @(negedge sys_clk);
        end
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while (!bus.TX_STATUS && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        chk("tx_idle_wait", int'(bus.TX_STATUS), 1);
    endtask

    task automatic rx_drained(input string name);
        chk({name, "_pending"}, rx_exp.size(), 0);
        chk({name, "_rx_data"}, int'(bus.RX_DATA), int'(last_good));
    endtask

    task automatic reset_checks(input string name);
        chk({name, "_uart_tx"}, int'(bus.UART_TX), 1);
        chk({name, "_tx_status"}, int'(bus.TX_STATUS), 1);
        chk({name, "_rx_status"}, int'(bus.RX_STATUS), 0);
        chk({name, "_rx_data"}, int'(bus.RX_DATA), 0);
    endtask

    // TX monitor: locks onto each start bit and checks latency, bit values and busy window.
    initial begin
        bit         in_frame;
        int         fall;
        int         off;
        logic       prev_tx;
        logic [9:0] bits;
        tx_item_t   cur;
        in_frame = 0;
        prev_tx  = 1'b1;
        bits     = '0;
        fall     = 0;
        forever begin
            @(negedge sys_clk);
            if (!reset) begin
                if (in_frame) chk("tx_abort_expected", int'(cur.ab), 1);
                in_frame = 0;
                prev_tx  = 1'b1;
            end else begin
                if (!in_frame) begin
                    if (prev_tx && !bus.UART_TX) begin
                        if (tx_exp.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL tx_unexpected_frame actual=start_bit required=idle_line (cycle %0d)", cyc);
                        end else begin
                            cur = tx_exp.pop_front();
                            chk("tx_start_latency", cyc - cur.req, 2);
                            chk("tx_status_busy", int'(bus.TX_STATUS), 0);
                            in_frame = 1;
                            fall     = cyc;
                        end
                    end
                end else begin
                    off = cyc - fall;
                    if (off % BIT == BIT / 2 && off < 10 * BIT) begin
                        bits[off / BIT] = bus.UART_TX;
                        chk("tx_status_mid", int'(bus.TX_STATUS), 0);
                    end
                    if (off == 10 * BIT - 1) chk("tx_status_last", int'(bus.TX_STATUS), 0);
                    if (off == 10 * BIT) begin
                        chk("tx_frame_bits", int'(bits), int'({1'b1, cur.data, 1'b0}));
                        chk("tx_status_done", int'(bus.TX_STATUS), 1);
                        chk("tx_line_idle", int'(bus.UART_TX), 1);
                        in_frame = 0;
                    end
                end
                prev_tx = bus.UART_TX;
            end
        end
    end

    // RX monitor: every RX_STATUS pulse must match the oldest queued good frame.
    initial begin
        logic     prev_st;
        rx_item_t it;
        int       lat;
        prev_st = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!reset) begin
                prev_st = 1'b0;
            end else begin
                if (bus.RX_STATUS) begin
                    chk("rx_pulse_width", int'(prev_st), 0);
                    if (!prev_st) begin
                        if (rx_exp.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_unexpected_pulse actual=pulse data=0x%0h required=no_pulse (cycle %0d)", bus.RX_DATA, cyc);
                        end else begin
                            it  = rx_exp.pop_front();
                            lat = cyc - it.fall;
                            chk("rx_data", int'(bus.RX_DATA), int'(it.data));
                            if (lat < 600 || lat > 620) begin
                                checks++;
                                errors++;
                                $display("FAIL rx_latency actual=%0d required=600..620", lat);
                            end else begin
                                checks++;
                            end
                            last_good = it.data;
                        end
                    end
                end
                prev_st = bus.RX_STATUS;
            end
        end
    end

    initial begin
        bus.TX_EN   = 1'b0;
        bus.TX_DATA = 8'h00;
        idle(4);
        reset_checks("in_reset");
        reset = 1'b1;
        idle(3);
        reset_checks("after_reset");

        // Transmit, mid-frame retrigger ignored, retrigger after idle, long hold sends one frame.
        tx_request(8'hA5, 10, 0);
        idle(300);
        tx_request(8'h3C, 10, 0);
        wait_tx_idle();
        idle(3);
        tx_request(8'h3C, 10, 0);
        wait_tx_idle();
        idle(5);
        tx_request(8'($urandom), 800, 0);
        wait_tx_idle();
        idle(5);
        chk("tx_all_sent", tx_exp.size(), 0);

        // Receive single, then back-to-back frames.
        send_rx(8'h5A, 1);
        idle(100);
        send_rx(8'hFF, 1);
        send_rx(8'h00, 1);
        idle(100);
        rx_drained("rx_b2b");

        // Glitch, framing error, recovery.
        rx_line = 1'b0;
        idle(20);
        rx_line = 1'b1;
        idle(200);
        send_rx(8'h81, 0);
        rx_line = 1'b1;
        idle(100);
        chk("rx_frame_err_hold", int'(bus.RX_DATA), int'(last_good));
        send_rx(8'h42, 1);
        idle(100);
        rx_drained("rx_recover");

        // Randomized concurrent traffic in both directions.
        fork
            for (int i = 0; i < 5; i++) begin
                tx_request(8'($urandom), $urandom_range(2, 20), 0);
                idle($urandom_range(0, 800));
            end
            for (int j = 0; j < 6; j++) begin
                send_rx(8'($urandom), 1);
                if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 200));
            end
        join
        idle(800);
        rx_drained("rx_random");
        chk("tx_random_sent", tx_exp.size(), 0);

        // Loopback, then reset during bit 4 of a new frame.
        loop_en = 1'b1;
        idle(10);
        tx_request(8'hC3, 5, 0);
        wait_tx_idle();
        idle(50);
        rx_drained("loopback");
        chk("loopback_c3", int'(bus.RX_DATA), 8'hC3);
        tx_request(8'($urandom), 5, 1);
        idle(275);
        reset = 1'b0;
        #1;
        reset_checks("mid_frame_reset");
        last_good = 8'h00;
        tx_free   = 0;
        idle(5);
        reset = 1'b1;
        idle(800);
        rx_drained("post_reset");
        chk("post_reset_tx_queue", tx_exp.size(), 0);
        chk("post_reset_uart_tx", int'(bus.UART_TX), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
